// File: rtl/hazard_ctrl_if.sv
// Hazard-control bus between the pipeline datapath (master) and hazard_ctrl (slave).
// Carries the hazard sources into the controller and the per-stage HzCtrl codes back out.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       IF_ID_RsAddr;
  logic [4:0]       IF_ID_RtAddr;
  logic             ID_UsesRt;
  logic             ID_Jump;
  logic             ID_EX_MemRd;
  logic [4:0]       ID_EX_RtAddr;
  logic             EX_BranchTaken;
  logic             MemReq;
  logic             MemReady;
  logic [1:0]       PC_HzCtrl;
  logic [1:0]       IF_ID_HzCtrl;
  logic [1:0]       ID_EX_HzCtrl;
  logic [1:0]       EX_MEM_HzCtrl;
  logic [1:0]       MEM_WB_HzCtrl;
  logic             MemTimeout;
  logic [CNT_W-1:0] StallCnt;
  logic [CNT_W-1:0] FlushCnt;

  modport master (
    output IF_ID_RsAddr, IF_ID_RtAddr, ID_UsesRt, ID_Jump,
           ID_EX_MemRd, ID_EX_RtAddr, EX_BranchTaken, MemReq, MemReady,
    input  PC_HzCtrl, IF_ID_HzCtrl, ID_EX_HzCtrl, EX_MEM_HzCtrl, MEM_WB_HzCtrl,
           MemTimeout, StallCnt, FlushCnt
  );

  modport slave (
    input  IF_ID_RsAddr, IF_ID_RtAddr, ID_UsesRt, ID_Jump,
           ID_EX_MemRd, ID_EX_RtAddr, EX_BranchTaken, MemReq, MemReady,
    output PC_HzCtrl, IF_ID_HzCtrl, ID_EX_HzCtrl, EX_MEM_HzCtrl, MEM_WB_HzCtrl,
           MemTimeout, StallCnt, FlushCnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: combinational per-stage stall/flush codes for load-use,
// taken branch, jump and data-memory wait, with a memory-timeout FSM and saturating statistics.
module hazard_ctrl #(
  parameter int unsigned STALL_MAX = 15,
  parameter int unsigned WAIT_W    = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  hz
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_MWAIT = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  localparam logic [1:0] HZ_NORM  = 2'b00;
  localparam logic [1:0] HZ_FLUSH = 2'b01;
  localparam logic [1:0] HZ_STALL = 2'b10;

  // Packed as PC / IF_ID / ID_EX / EX_MEM / MEM_WB, PC in the top bits.
  localparam logic [9:0] CTRL_NONE   = {HZ_NORM,  HZ_NORM,  HZ_NORM,  HZ_NORM,  HZ_NORM};
  localparam logic [9:0] CTRL_MEMW   = {HZ_STALL, HZ_STALL, HZ_STALL, HZ_STALL, HZ_FLUSH};
  localparam logic [9:0] CTRL_BRANCH = {HZ_NORM,  HZ_FLUSH, HZ_FLUSH, HZ_NORM,  HZ_NORM};
  localparam logic [9:0] CTRL_LU     = {HZ_STALL, HZ_STALL, HZ_FLUSH, HZ_NORM,  HZ_NORM};
  localparam logic [9:0] CTRL_JUMP   = {HZ_NORM,  HZ_FLUSH, HZ_NORM,  HZ_NORM,  HZ_NORM};

  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(STALL_MAX);

  logic [1:0]        r_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_timeout;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic [1:0]        w_next_state;
  logic [WAIT_W-1:0] w_wait_nxt;
  logic              w_timeout_set;
  logic              w_lu;
  logic              w_mw;
  logic [9:0]        w_run_ctrl;
  logic [9:0]        w_fsm_ctrl;
  logic [9:0]        w_ctrl;

  assign w_lu = hz.ID_EX_MemRd && (hz.ID_EX_RtAddr != 5'd0) &&
                ((hz.ID_EX_RtAddr == hz.IF_ID_RsAddr) ||
                 (hz.ID_UsesRt && (hz.ID_EX_RtAddr == hz.IF_ID_RtAddr)));
  assign w_mw = hz.MemReq && !hz.MemReady;

  // Non-memory hazards in priority order; shared by RUN and the MWAIT release cycle.
  always_comb begin
    w_run_ctrl = CTRL_NONE;
    if (hz.EX_BranchTaken) begin
      w_run_ctrl = CTRL_BRANCH;
    end else if (w_lu) begin
      w_run_ctrl = CTRL_LU;
    end else if (hz.ID_Jump) begin
      w_run_ctrl = CTRL_JUMP;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_wait_nxt    = r_wait_cnt;
    w_timeout_set = 1'b0;
    w_fsm_ctrl    = CTRL_NONE;
    case (r_state)
      ST_RUN: begin
        if (w_mw) begin
          w_fsm_ctrl   = CTRL_MEMW;
          w_next_state = ST_MWAIT;
          w_wait_nxt   = WAIT_W'(1);
        end else begin
          w_fsm_ctrl = w_run_ctrl;
        end
      end
      ST_MWAIT: begin
        if (hz.MemReady) begin
          w_fsm_ctrl   = w_run_ctrl;
          w_next_state = ST_RUN;
          w_wait_nxt   = '0;
        end else begin
          w_fsm_ctrl = CTRL_MEMW;
          if (r_wait_cnt < WAIT_LIMIT) begin
            w_wait_nxt = r_wait_cnt + WAIT_W'(1);
          end else begin
            w_next_state  = ST_HALT;
            w_timeout_set = 1'b1;
          end
        end
      end
      ST_HALT: begin
        w_fsm_ctrl = CTRL_MEMW;
      end
      default: begin
        w_fsm_ctrl   = CTRL_NONE;
        w_next_state = ST_RUN;
        w_wait_nxt   = '0;
      end
    endcase
  end

  assign w_ctrl = rst ? w_fsm_ctrl : CTRL_NONE;

  assign hz.PC_HzCtrl     = w_ctrl[9:8];
  assign hz.IF_ID_HzCtrl  = w_ctrl[7:6];
  assign hz.ID_EX_HzCtrl  = w_ctrl[5:4];
  assign hz.EX_MEM_HzCtrl = w_ctrl[3:2];
  assign hz.MEM_WB_HzCtrl = w_ctrl[1:0];
  assign hz.MemTimeout    = r_timeout;
  assign hz.StallCnt      = r_stall_cnt;
  assign hz.FlushCnt      = r_flush_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_RUN;
      r_wait_cnt  <= '0;
      r_timeout   <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_wait_nxt;
      if (w_timeout_set) begin
        r_timeout <= 1'b1;
      end
      if ((w_ctrl[9:8] == HZ_STALL) && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if ((w_ctrl[7:6] == HZ_FLUSH) && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized + directed bench for hazard_ctrl with a queue scoreboard against a
// cycle-level reference model (STALL_MAX=3, CNT_W=4 so timeout and saturation are reachable).
module tb_hazard_ctrl;

  localparam int STALL_MAX = 3;
  localparam int CNT_W     = 4;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [9:0]       ctrl;
    logic             to;
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] flush;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  hazard_ctrl #(
    .STALL_MAX(STALL_MAX),
    .WAIT_W   (2),
    .CNT_W    (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz (bus)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  bit   drv_done    = 1'b0;

  // Reference model: how many cycles memory has been outstanding, and whether we gave up.
  int m_pending = 0;
  bit m_halted  = 1'b0;
  bit m_to      = 1'b0;
  int m_stall   = 0;
  int m_flush   = 0;

  function automatic logic [9:0] hazard_codes(input bit bt, input bit lu, input bit jmp);
    if (bt)  return 10'b00_01_01_00_00;
    if (lu)  return 10'b10_10_01_00_00;
    if (jmp) return 10'b00_01_00_00_00;
    return 10'b0;
  endfunction

  task automatic issue();
    logic [9:0] c;
    bit lu, mw;
    exp_t e;
    lu = bus.ID_EX_MemRd && bus.ID_EX_RtAddr != 0 &&
         (bus.ID_EX_RtAddr == bus.IF_ID_RsAddr ||
          (bus.ID_UsesRt && bus.ID_EX_RtAddr == bus.IF_ID_RtAddr));
    mw = bus.MemReq && !bus.MemReady;
    if (!rst)                          c = 10'b0;
    else if (m_halted)                 c = 10'b10_10_10_10_01;
    else if (m_pending > 0 && !bus.MemReady) c = 10'b10_10_10_10_01;
    else if (m_pending == 0 && mw)     c = 10'b10_10_10_10_01;
    else                               c = hazard_codes(bus.EX_BranchTaken, lu, bus.ID_Jump);
    e.ctrl  = c;
    e.to    = m_to;
    e.stall = CNT_W'(m_stall);
    e.flush = CNT_W'(m_flush);
    q.push_back(e);
    // advance model to the state after the coming edge
    if (c[9:8] == 2'b10 && m_stall < CNT_MAX) m_stall++;
    if (c[7:6] == 2'b01 && m_flush < CNT_MAX) m_flush++;
    if (!rst) begin
      m_pending = 0; m_halted = 0; m_to = 0; m_stall = 0; m_flush = 0;
    end else if (!m_halted) begin
      if (m_pending > 0) begin
        if (bus.MemReady) m_pending = 0;
        else if (m_pending == STALL_MAX) begin m_halted = 1; m_to = 1; end
        else m_pending++;
      end else if (mw) begin
        m_pending = 1;
      end
    end
  endtask

  task automatic cyc(input bit r, input int rs, input int rt, input bit uses_rt, input bit jmp,
                     input bit memrd, input int exrt, input bit bt, input bit req, input bit rdy);
    @(negedge clk);
    rst                = r;
    bus.IF_ID_RsAddr   = 5'(rs);
    bus.IF_ID_RtAddr   = 5'(rt);
    bus.ID_UsesRt      = uses_rt;
    bus.ID_Jump        = jmp;
    bus.ID_EX_MemRd    = memrd;
    bus.ID_EX_RtAddr   = 5'(exrt);
    bus.EX_BranchTaken = bt;
    bus.MemReq         = req;
    bus.MemReady       = rdy;
    issue();
  endtask

  task automatic rnd_cyc(input bit r);
    cyc(r, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), ($urandom_range(0, 5) == 0),
        1'($urandom), $urandom_range(0, 3), ($urandom_range(0, 5) == 0),
        ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0));
  endtask

  task automatic chk(input string name, input int act, input int exp);
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: outputs are valid every cycle once settled after the input change.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        vectors++;
        chk("PC_HzCtrl",     int'(bus.PC_HzCtrl),     int'(e.ctrl[9:8]));
        chk("IF_ID_HzCtrl",  int'(bus.IF_ID_HzCtrl),  int'(e.ctrl[7:6]));
        chk("ID_EX_HzCtrl",  int'(bus.ID_EX_HzCtrl),  int'(e.ctrl[5:4]));
        chk("EX_MEM_HzCtrl", int'(bus.EX_MEM_HzCtrl), int'(e.ctrl[3:2]));
        chk("MEM_WB_HzCtrl", int'(bus.MEM_WB_HzCtrl), int'(e.ctrl[1:0]));
        chk("MemTimeout",    int'(bus.MemTimeout),    int'(e.to));
        chk("StallCnt",      int'(bus.StallCnt),      int'(e.stall));
        chk("FlushCnt",      int'(bus.FlushCnt),      int'(e.flush));
      end
    end
  end

  initial begin
    // reset with random inputs
    rnd_cyc(0);
    rnd_cyc(0);
    // load-use, then same with r0 destination
    cyc(1, 5, 9, 0, 0, 1, 5, 0, 0, 0);
    cyc(1, 0, 9, 0, 0, 1, 0, 0, 0, 0);
    cyc(1, 2, 7, 1, 0, 1, 7, 0, 0, 0);
    cyc(1, 2, 7, 0, 0, 1, 7, 0, 0, 0);
    // branch together with load-use and jump
    cyc(1, 5, 9, 0, 1, 1, 5, 1, 0, 0);
    cyc(1, 1, 2, 0, 1, 0, 0, 0, 0, 0);
    // memory wait 3 cycles then release with a pending load-use
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 4, 0, 0, 1, 1, 4, 1, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 4, 0, 0, 0, 1, 4, 0, 1, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // ready already high
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    // timeout and halt, then reset out of it
    for (int i = 0; i < 8; i++) cyc(1, 3, 0, 0, 1, 1, 3, 1, 1, (i > 5));
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // saturate StallCnt and FlushCnt
    for (int i = 0; i < 20; i++) cyc(1, 6, 0, 0, 0, 1, 6, 0, 0, 0);
    for (int i = 0; i < 20; i++) cyc(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    // randomized traffic with occasional resets
    for (int i = 0; i < 800; i++) rnd_cyc(($urandom_range(0, 39) != 0));
    drv_done = 1'b1;
    @(negedge clk);
    #4;
    vectors++;
    chk("scoreboard_drain", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
